// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute over one shared
// memory port, one ALU and the register file, and counts retired instructions.
module multicycle_ctrl #(
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             is_zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic [1:0]       imm_src,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             f3_alu_ok;
    logic [2:0]       alu_dec;
    state_t           illegal_next;
    logic             pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;

    assign f3_alu_ok    = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                          (funct3 == 3'b110) || (funct3 == 3'b111);
    assign illegal_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

    always_comb begin
        case (funct3)
            3'b000:  alu_dec = ((op == OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = f3_alu_ok ? S_EXECR : illegal_next;
                    OP_I:         state_d = f3_alu_ok ? S_EXECI : illegal_next;
                    OP_BEQ:       state_d = (funct3 == 3'b000) ? S_BEQ : illegal_next;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = illegal_next;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR,
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // Every completed instruction (including a NOP'd illegal one) re-enters FETCH exactly once.
    assign retired_d = ((state_d == S_FETCH) && (state_q != S_FETCH)) ?
                       retired_q + CNT_W'(1) : retired_q;

    always_comb begin
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        adr_src       = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_ctrl      = ALU_ADD;
        halted        = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_ctrl  = alu_dec;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = alu_dec;
            end
            S_ALUWB:    reg_write_raw = 1'b1;
            S_BEQ: begin
                alu_src_a    = 2'b10;
                alu_ctrl     = ALU_SUB;
                pc_write_raw = is_zero;
            end
            S_JAL: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                pc_write_raw = 1'b1;
            end
            S_HALT:     halted = 1'b1;
            default: ;
        endcase
    end

    // Reset is asynchronous, so enables are masked directly to keep writes quiet while it is held.
    assign pc_write  = pc_write_raw  & ~rst;
    assign mem_write = mem_write_raw & ~rst;
    assign ir_write  = ir_write_raw  & ~rst;
    assign reg_write = reg_write_raw & ~rst;
    assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction step-list model with random stalls,
// branch outcomes and instruction mixes, plus directed reset/halt scenarios.
module tb_multicycle_ctrl;

    localparam int CNT_W = 32;

    logic clk, rst, funct7b5, is_zero, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic pc_write, adr_src, mem_write, ir_write, reg_write, halted;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_ctrl;
    logic [CNT_W-1:0] retired;

    int checks = 0, passes = 0;
    int exp_ret = 0;

    multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .is_zero(is_zero), .mem_ready(mem_ready), .pc_write(pc_write),
        .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .imm_src(imm_src),
        .halted(halted), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pcm: 0 never, 1 always, 2 when mem_ready, 3 when is_zero
    typedef struct {
        bit       wm;
        bit [1:0] pcm;
        bit       irm;
        bit       rw;
        bit       mw;
        bit       adr;
        bit [2:0] alu;
        bit [1:0] sa, sb, rs;
        bit       h;
    } step_t;

    function automatic step_t mk(bit wm, bit [1:0] pcm, bit irm, bit rw, bit mw, bit adr,
                                 bit [2:0] alu, bit [1:0] sa, bit [1:0] sb, bit [1:0] rs, bit h);
        step_t s;
        s.wm = wm; s.pcm = pcm; s.irm = irm; s.rw = rw; s.mw = mw; s.adr = adr;
        s.alu = alu; s.sa = sa; s.sb = sb; s.rs = rs; s.h = h;
        return s;
    endfunction

    function automatic bit f3ok(logic [2:0] f);
        return f == 3'd0 || f == 3'd2 || f == 3'd6 || f == 3'd7;
    endfunction

    function automatic logic [2:0] exp_alu(logic [6:0] o, logic [2:0] f, logic b5);
        if (f == 3'd2) return 3'b101;
        if (f == 3'd6) return 3'b011;
        if (f == 3'd7) return 3'b010;
        if (o == 7'b0110011 && b5) return 3'b001;
        return 3'b000;
    endfunction

    // Runs one instruction through the model; stalls apply to the data-memory step in directed mode.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic b5,
                             input bit rnd, input int stalls, input bit zero,
                             output int cycles, output int mw_cnt, output int rw_cnt, output int pw_cnt);
        step_t q[$];
        bit illegal = 0;
        logic [1:0] e_imm;
        logic [14:0] obs, e;
        logic e_pc;
        op = o; funct3 = f; funct7b5 = b5;
        cycles = 0; mw_cnt = 0; rw_cnt = 0; pw_cnt = 0;
        q.push_back(mk(1, 2, 1, 0, 0, 0, 3'b000, 2'd0, 2'd2, 2'd2, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000, 2'd1, 2'd1, 2'd0, 0));
        case (o)
            7'b0000011: begin
                q.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000, 2'd2, 2'd1, 2'd0, 0));
                q.push_back(mk(1, 0, 0, 0, 0, 1, 3'b000, 2'd0, 2'd0, 2'd0, 0));
                q.push_back(mk(0, 0, 0, 1, 0, 0, 3'b000, 2'd0, 2'd0, 2'd1, 0));
            end
            7'b0100011: begin
                q.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000, 2'd2, 2'd1, 2'd0, 0));
                q.push_back(mk(1, 0, 0, 0, 1, 1, 3'b000, 2'd0, 2'd0, 2'd0, 0));
            end
            7'b0110011, 7'b0010011: begin
                if (!f3ok(f)) illegal = 1;
                else begin
                    q.push_back(mk(0, 0, 0, 0, 0, 0, exp_alu(o, f, b5), 2'd2,
                                   (o == 7'b0110011) ? 2'd0 : 2'd1, 2'd0, 0));
                    q.push_back(mk(0, 0, 0, 1, 0, 0, 3'b000, 2'd0, 2'd0, 2'd0, 0));
                end
            end
            7'b1100011: begin
                if (f != 3'd0) illegal = 1;
                else q.push_back(mk(0, 3, 0, 0, 0, 0, 3'b001, 2'd2, 2'd0, 2'd0, 0));
            end
            7'b1101111: begin
                q.push_back(mk(0, 1, 0, 0, 0, 0, 3'b000, 2'd1, 2'd2, 2'd0, 0));
                q.push_back(mk(0, 0, 0, 1, 0, 0, 3'b000, 2'd0, 2'd0, 2'd0, 0));
            end
            default: illegal = 1;
        endcase
        if (illegal) q.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000, 2'd0, 2'd0, 2'd0, 1));
        e_imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 :
                (o == 7'b1101111) ? 2'b11 : 2'b00;
        foreach (q[i]) begin
            for (int k = 0; ; k++) begin
                @(negedge clk);
                if (rnd) begin
                    mem_ready = ($urandom_range(0, 3) != 0);
                    is_zero   = $urandom_range(0, 1);
                end else begin
                    mem_ready = !(q[i].wm && i > 0 && k < stalls);
                    is_zero   = zero;
                end
                #1;
                cycles++;
                case (q[i].pcm)
                    2'd0: e_pc = 1'b0;
                    2'd1: e_pc = 1'b1;
                    2'd2: e_pc = mem_ready;
                    default: e_pc = is_zero;
                endcase
                e   = {e_pc, q[i].irm & mem_ready, q[i].rw, q[i].mw, q[i].adr, q[i].alu,
                       q[i].sa, q[i].sb, q[i].rs, q[i].h};
                obs = {pc_write, ir_write, reg_write, mem_write, adr_src, alu_ctrl,
                       alu_src_a, alu_src_b, result_src, halted};
                checks++;
                if (obs !== e)
                    $display("FAIL ctrl op=%b f3=%b step=%0d cyc=%0d: got %b expected %b",
                             o, f, i, k, obs, e);
                else passes++;
                if (i == 0 && k == 0) begin
                    checks++;
                    if (imm_src !== e_imm)
                        $display("FAIL imm_src op=%b: got %b expected %b", o, imm_src, e_imm);
                    else passes++;
                end
                mw_cnt += int'(mem_write); rw_cnt += int'(reg_write); pw_cnt += int'(pc_write);
                if (q[i].h) begin
                    if (k >= 7) break;
                end else if (!q[i].wm || mem_ready) break;
                if (k > 200) begin
                    checks++;
                    $display("FAIL timeout op=%b step=%0d: got no progress expected completion", o, i);
                    break;
                end
            end
        end
        @(posedge clk); #1;
        if (!illegal) exp_ret++;
        checks++;
        if (retired !== CNT_W'(exp_ret))
            $display("FAIL retired op=%b: got %0d expected %0d", o, retired, exp_ret);
        else passes++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1; is_zero = 1'b1;
        exp_ret = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({pc_write, ir_write, reg_write, mem_write, halted} !== 5'b0 || retired !== '0)
                $display("FAIL reset_hold: got en=%b ret=%0d expected en=00000 ret=0",
                         {pc_write, ir_write, reg_write, mem_write, halted}, retired);
            else passes++;
            @(negedge clk);
        end
        rst = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0;
        do_reset();
    endtask

    task automatic test_rtype_sub();
        int cy, mw, rw, pw;
        run_instr(7'b0110011, 3'd0, 1'b1, 0, 0, 0, cy, mw, rw, pw);
        checks++;
        if (cy != 4 || rw != 1 || pw != 1)
            $display("FAIL rtype_sub: got cyc=%0d rw=%0d pw=%0d expected 4/1/1", cy, rw, pw);
        else passes++;
    endtask

    task automatic test_lw_stall();
        int cy, mw, rw, pw;
        run_instr(7'b0000011, 3'd2, 1'b0, 0, 3, 0, cy, mw, rw, pw);
        checks++;
        if (cy != 8 || rw != 1 || mw != 0)
            $display("FAIL lw_stall: got cyc=%0d rw=%0d mw=%0d expected 8/1/0", cy, rw, mw);
        else passes++;
    endtask

    task automatic test_sw_stall();
        int cy, mw, rw, pw;
        run_instr(7'b0100011, 3'd2, 1'b0, 0, 2, 0, cy, mw, rw, pw);
        checks++;
        if (cy != 6 || mw != 3 || rw != 0)
            $display("FAIL sw_stall: got cyc=%0d mw=%0d rw=%0d expected 6/3/0", cy, mw, rw);
        else passes++;
    endtask

    task automatic test_beq();
        int cy, mw, rw, pw;
        run_instr(7'b1100011, 3'd0, 1'b0, 0, 0, 1, cy, mw, rw, pw);
        checks++;
        if (pw != 2 || cy != 3) $display("FAIL beq_taken: got pw=%0d cyc=%0d expected 2/3", pw, cy);
        else passes++;
        run_instr(7'b1100011, 3'd0, 1'b0, 0, 0, 0, cy, mw, rw, pw);
        checks++;
        if (pw != 1 || cy != 3) $display("FAIL beq_not_taken: got pw=%0d cyc=%0d expected 1/3", pw, cy);
        else passes++;
    endtask

    task automatic test_jal();
        int cy, mw, rw, pw;
        run_instr(7'b1101111, 3'd0, 1'b0, 0, 0, 0, cy, mw, rw, pw);
        checks++;
        if (pw != 2 || rw != 1 || cy != 4)
            $display("FAIL jal: got pw=%0d rw=%0d cyc=%0d expected 2/1/4", pw, rw, cy);
        else passes++;
    endtask

    task automatic test_random_mix();
        int cy, mw, rw, pw;
        logic [6:0] ops [6];
        logic [2:0] f3s [4];
        logic [6:0] o;
        logic [2:0] f;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        f3s[0] = 3'd0; f3s[1] = 3'd2; f3s[2] = 3'd6; f3s[3] = 3'd7;
        for (int n = 0; n < 40; n++) begin
            o = ops[$urandom_range(0, 5)];
            f = (o == 7'b1100011) ? 3'd0 : f3s[$urandom_range(0, 3)];
            run_instr(o, f, 1'($urandom_range(0, 1)), 1, 0, 0, cy, mw, rw, pw);
        end
    endtask

    task automatic test_illegal();
        int cy, mw, rw, pw;
        run_instr(7'b0000000, 3'd0, 1'b0, 0, 0, 0, cy, mw, rw, pw);
        do_reset();
        run_instr(7'b0110011, 3'd1, 1'b0, 0, 0, 0, cy, mw, rw, pw);
        do_reset();
        run_instr(7'b1100011, 3'd1, 1'b0, 0, 0, 0, cy, mw, rw, pw);
        do_reset();
    endtask

    task automatic test_reset_mid_store();
        op = 7'b0100011; funct3 = 3'd2; funct7b5 = 1'b0;
        @(negedge clk); mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (mem_write !== 1'b1) $display("FAIL mid_store_pre: got mem_write=%b expected 1", mem_write);
        else passes++;
        rst = 1'b1; mem_ready = 1'b1; #1;
        checks++;
        if ({mem_write, ir_write, pc_write, reg_write, adr_src} !== 5'b0)
            $display("FAIL mid_store_rst: got %b expected 00000",
                     {mem_write, ir_write, pc_write, reg_write, adr_src});
        else passes++;
        do_reset();
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; is_zero = 1'b0;
        op = '0; funct3 = '0; funct7b5 = 1'b0;
        test_reset();
        test_rtype_sub();
        test_lw_stall();
        test_sw_stall();
        test_beq();
        test_jal();
        test_random_mix();
        test_illegal();
        test_reset_mid_store();
        test_rtype_sub();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
